// File: rtl/multi_target_firing.sv
// Shot-resolution unit: per-round shot budget, rectangle-overlap hit test against NBIRD birds.
// Optional post-shot lockout state enabled by defining MULTI_TARGET_FIRING_COOLDOWN_EN.
module multi_target_firing #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int NBIRD    = 2,
    parameter int SHOTS    = 3,
    parameter int PW       = 3,
    parameter int BW       = 4,
    parameter int COOLDOWN = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fire,
    input  logic                  reload,
    input  logic [XW-1:0]         player_x,
    input  logic [YW-1:0]         player_y,
    input  logic [NBIRD*XW-1:0]   bird_x,
    input  logic [NBIRD*YW-1:0]   bird_y,
    input  logic [NBIRD-1:0]      bird_alive,
    output logic [3:0]            shots_left,
    output logic [NBIRD-1:0]      hit,
    output logic [NBIRD-1:0]      hit_mask,
    output logic                  round_done,
    output logic                  escape,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CHECK, COOL, EMPTY} state_t;

    localparam logic [3:0]  SHOTS_INIT = 4'(SHOTS);
    localparam logic [XW:0] PX_OFF     = (XW+1)'(PW - 1);
    localparam logic [XW:0] BX_OFF     = (XW+1)'(BW - 1);
    localparam logic [YW:0] PY_OFF     = (YW+1)'(PW - 1);
    localparam logic [YW:0] BY_OFF     = (YW+1)'(BW - 1);

    state_t               state_q;
    logic [3:0]           shots_q;
    logic [NBIRD-1:0]     hit_q, mask_q, alive_q;
    logic                 done_q, esc_q;
    logic [XW-1:0]        px_q;
    logic [YW-1:0]        py_q;
    logic [NBIRD*XW-1:0]  bx_q;
    logic [NBIRD*YW-1:0]  by_q;
    logic [NBIRD-1:0]     strike_d, mask_d;
    logic                 done_d, esc_d, accept;

    // One extra bit keeps the edge sums from wrapping at the screen border.
    function automatic logic ovl_x(input logic [XW-1:0] p, input logic [XW-1:0] b);
        return ({1'b0, p} <= {1'b0, b} + BX_OFF) && ({1'b0, b} <= {1'b0, p} + PX_OFF);
    endfunction

    function automatic logic ovl_y(input logic [YW-1:0] p, input logic [YW-1:0] b);
        return ({1'b0, p} <= {1'b0, b} + BY_OFF) && ({1'b0, b} <= {1'b0, p} + PY_OFF);
    endfunction

    assign accept = (state_q == IDLE) && fire && !reload && (shots_q != 4'd0);

    always_comb begin
        strike_d = '0;
        for (int i = 0; i < NBIRD; i++) begin
            strike_d[i] = alive_q[i] & ~mask_q[i]
                        & ovl_x(px_q, bx_q[i*XW +: XW])
                        & ovl_y(py_q, by_q[i*YW +: YW]);
        end
        mask_d = mask_q | strike_d;
        done_d = (alive_q != '0) && ((alive_q & ~mask_d) == '0);
        esc_d  = (shots_q == 4'd0) && ((alive_q & ~mask_d) != '0);
    end

    // Shot snapshot: bird inputs may move freely once the shot is taken.
    always_ff @(posedge clk) begin
        if (accept) begin
            px_q    <= player_x;
            py_q    <= player_y;
            bx_q    <= bird_x;
            by_q    <= bird_y;
            alive_q <= bird_alive;
        end
    end

`ifdef MULTI_TARGET_FIRING_COOLDOWN_EN
    logic [7:0] cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^8'(COOLDOWN);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shots_q <= SHOTS_INIT;
            hit_q   <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
`ifdef MULTI_TARGET_FIRING_COOLDOWN_EN
            cnt_q   <= 8'd0;
`endif
        end else if (reload) begin
            state_q <= IDLE;
            shots_q <= SHOTS_INIT;
            hit_q   <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
`ifdef MULTI_TARGET_FIRING_COOLDOWN_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            hit_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shots_q <= shots_q - 4'd1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    hit_q  <= strike_d;
                    mask_q <= mask_d;
                    done_q <= done_q | done_d;
                    esc_q  <= esc_q | esc_d;
                    if (done_d || shots_q == 4'd0) begin
                        state_q <= EMPTY;
                    end else begin
`ifdef MULTI_TARGET_FIRING_COOLDOWN_EN
                        cnt_q   <= 8'(COOLDOWN - 1);
                        state_q <= COOL;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef MULTI_TARGET_FIRING_COOLDOWN_EN
                COOL: begin
                    if (cnt_q == 8'd0) state_q <= IDLE;
                    else               cnt_q   <= cnt_q - 8'd1;
                end
`endif
                EMPTY: state_q <= EMPTY;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shots_left = shots_q;
    assign hit        = hit_q;
    assign hit_mask   = mask_q;
    assign round_done = done_q;
    assign escape     = esc_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/multi_target_firing.md
# multi_target_firing

Parametrised shot-resolution unit for the gameplay datapath. It accepts fire requests from the player controller and tracks a per-round shot budget. Each shot is checked against N birds using full rectangle overlap, and the unit reports per-bird hits, round completion and bird escape. It sits between the input/cursor logic and the bird-motion and score units.

## Interface
Parameters:
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- NBIRD, 2, number of birds (1..8)
- SHOTS, 3, shots per round (1..15)
- PW, 3, player reticle side length in pixels
- BW, 4, bird hitbox side length in pixels
- COOLDOWN, 4, cycles of lockout after each shot (1..255, only with cooldown enabled)

Ports:
- clk, in, 1, system clock, all logic on rising edge
- reset_n, in, 1, asynchronous active-low reset
- fire, in, 1, shot request, sampled each cycle
- reload, in, 1, start a new round
- player_x, in, XW, reticle top-left x
- player_y, in, YW, reticle top-left y
- bird_x, in, NBIRD*XW, packed bird x values; bird i occupies bits [i*XW +: XW]
- bird_y, in, NBIRD*YW, packed bird y values, same packing
- bird_alive, in, NBIRD, bird is on screen and targetable
- shots_left, out, 4, remaining shots
- hit, out, NBIRD, one-cycle pulse per bird struck
- hit_mask, out, NBIRD, sticky record of birds struck this round
- round_done, out, 1, every alive bird has been struck
- escape, out, 1, shots exhausted with an alive bird unstruck
- busy, out, 1, high when state is not IDLE

## Operation
- States: IDLE, CHECK, COOL, EMPTY.
- IDLE, on fire with shots_left>0:
  - latch player_x/y, bird_x/y and bird_alive;
  - shots_left decrements by 1;
  - go to CHECK.
- IDLE, on fire with shots_left==0: fire is ignored.
- CHECK, for each bird i, hit condition is all of:
  - bird i is latched alive;
  - hit_mask[i]==0;
  - x overlap: px <= bx+BW-1 and bx <= px+PW-1;
  - y overlap: same rule using py, by.
- Overlap sums use XW+1 and YW+1 bits, so there is no wrap-around at the screen edge.
- One shot may strike several birds.
- CHECK actions: hit pulses for struck birds; hit_mask |= struck birds.
- round_done sets when the latched alive mask is non-zero and alive & ~new hit_mask == 0.
- escape sets when the new shots_left==0 and alive & ~new hit_mask != 0.
- CHECK exit:
  - to EMPTY if round_done or shots_left==0;
  - else to COOL (cooldown enabled) or IDLE.
- COOL: an 8-bit counter loads COOLDOWN-1 on entry and counts down; at 0 the block returns to IDLE. Fire is ignored throughout COOL.
- EMPTY: all fire is ignored; the block waits for reload.
- reload, in any state:
  - next cycle: shots_left=SHOTS, hit_mask=0, hit=0, round_done=0, escape=0, counter cleared;
  - state goes to IDLE;
  - an in-flight CHECK is discarded.
- reload and fire in the same cycle: reload wins and the shot is not consumed.
- Bird inputs may change at any time; only the values latched at the fire edge are used.

## Timing
- Reset values: shots_left=SHOTS, hit=0, hit_mask=0, round_done=0, escape=0, busy=0, state IDLE.
- Reset takes effect immediately when asserted, including mid-CHECK or mid-COOL.
- Fire sampled at edge T:
  - shots_left and busy update after T;
  - hit, hit_mask, round_done and escape update after T+1;
  - hit pulses are high for exactly the cycle following T+1.
- Without cooldown, the next fire is accepted at T+2 at the earliest.
- With cooldown, the next fire is accepted at T+2+COOLDOWN at the earliest.
- round_done and escape are levels held until reload or reset; they are never both set.

## Configuration
- Macro: MULTI_TARGET_FIRING_COOLDOWN_EN.
- Defined: the COOL state and its counter exist, and the COOLDOWN parameter applies.
- Undefined: CHECK goes directly to IDLE or EMPTY, the COOLDOWN parameter is ignored, and no counter is synthesised.

## Test plan
- Bird0 at (10,20) alive, player at (12,22), fire -> hit=01 for one cycle at T+2, hit_mask=01, shots_left=2.
- Player at (8,18) with PW=3: corner overlap at px+2=bx, py+2=by -> hit. Player at (7,17) -> no hit.
- Birds 0 and 1 both at (40,40), player at (41,41), one fire -> hit=11, round_done=1, state EMPTY; a further fire leaves shots_left unchanged.
- Three fires all missing alive bird0 -> shots_left 2,1,0, escape=1 after the third CHECK; a fourth fire is ignored; reload -> shots_left=3, escape=0.
- Cooldown build, COOLDOWN=4: fire at T and again at T+3 -> second fire ignored, busy high; fire at T+6 -> accepted.
- reload asserted together with fire, and separately reset_n pulsed low mid-CHECK -> no shot consumed; all outputs at reset/reload values.
